// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, inverse S-box table, state byte indexing and FSM encoding
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NBYTES  = AES_BLOCK_W / AES_BYTE_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Byte i of the state sits at row i%4, column i/4.
  function automatic logic [1:0] st_row(input logic [3:0] idx);
    return idx[1:0];
  endfunction

  function automatic logic [1:0] st_col(input logic [3:0] idx);
    return idx[3:2];
  endfunction

  function automatic logic [3:0] st_idx(input logic [1:0] row, input logic [1:0] col);
    return {col, row};
  endfunction

endpackage

// File: rtl/inverse_substitution_box.sv
// rtl/inverse_substitution_box.sv - combinational AES inverse S-box ROM
// clk/rst keep the port list identical to the forward box; the ROM itself has no state.
module inverse_substitution_box
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AES_BYTE_W-1:0] A,
  output logic [AES_BYTE_W-1:0] C
);

  logic unused;
  assign unused = clk ^ rst;

  always_comb begin
    C = 8'h00;
    case (A)
      8'h00: C = 8'h52; 8'h01: C = 8'h09; 8'h02: C = 8'h6a; 8'h03: C = 8'hd5; 8'h04: C = 8'h30; 8'h05: C = 8'h36; 8'h06: C = 8'ha5; 8'h07: C = 8'h38;
      8'h08: C = 8'hbf; 8'h09: C = 8'h40; 8'h0a: C = 8'ha3; 8'h0b: C = 8'h9e; 8'h0c: C = 8'h81; 8'h0d: C = 8'hf3; 8'h0e: C = 8'hd7; 8'h0f: C = 8'hfb;
      8'h10: C = 8'h7c; 8'h11: C = 8'he3; 8'h12: C = 8'h39; 8'h13: C = 8'h82; 8'h14: C = 8'h9b; 8'h15: C = 8'h2f; 8'h16: C = 8'hff; 8'h17: C = 8'h87;
      8'h18: C = 8'h34; 8'h19: C = 8'h8e; 8'h1a: C = 8'h43; 8'h1b: C = 8'h44; 8'h1c: C = 8'hc4; 8'h1d: C = 8'hde; 8'h1e: C = 8'he9; 8'h1f: C = 8'hcb;
      8'h20: C = 8'h54; 8'h21: C = 8'h7b; 8'h22: C = 8'h94; 8'h23: C = 8'h32; 8'h24: C = 8'ha6; 8'h25: C = 8'hc2; 8'h26: C = 8'h23; 8'h27: C = 8'h3d;
      8'h28: C = 8'hee; 8'h29: C = 8'h4c; 8'h2a: C = 8'h95; 8'h2b: C = 8'h0b; 8'h2c: C = 8'h42; 8'h2d: C = 8'hfa; 8'h2e: C = 8'hc3; 8'h2f: C = 8'h4e;
      8'h30: C = 8'h08; 8'h31: C = 8'h2e; 8'h32: C = 8'ha1; 8'h33: C = 8'h66; 8'h34: C = 8'h28; 8'h35: C = 8'hd9; 8'h36: C = 8'h24; 8'h37: C = 8'hb2;
      8'h38: C = 8'h76; 8'h39: C = 8'h5b; 8'h3a: C = 8'ha2; 8'h3b: C = 8'h49; 8'h3c: C = 8'h6d; 8'h3d: C = 8'h8b; 8'h3e: C = 8'hd1; 8'h3f: C = 8'h25;
      8'h40: C = 8'h72; 8'h41: C = 8'hf8; 8'h42: C = 8'hf6; 8'h43: C = 8'h64; 8'h44: C = 8'h86; 8'h45: C = 8'h68; 8'h46: C = 8'h98; 8'h47: C = 8'h16;
      8'h48: C = 8'hd4; 8'h49: C = 8'ha4; 8'h4a: C = 8'h5c; 8'h4b: C = 8'hcc; 8'h4c: C = 8'h5d; 8'h4d: C = 8'h65; 8'h4e: C = 8'hb6; 8'h4f: C = 8'h92;
      8'h50: C = 8'h6c; 8'h51: C = 8'h70; 8'h52: C = 8'h48; 8'h53: C = 8'h50; 8'h54: C = 8'hfd; 8'h55: C = 8'hed; 8'h56: C = 8'hb9; 8'h57: C = 8'hda;
      8'h58: C = 8'h5e; 8'h59: C = 8'h15; 8'h5a: C = 8'h46; 8'h5b: C = 8'h57; 8'h5c: C = 8'ha7; 8'h5d: C = 8'h8d; 8'h5e: C = 8'h9d; 8'h5f: C = 8'h84;
      8'h60: C = 8'h90; 8'h61: C = 8'hd8; 8'h62: C = 8'hab; 8'h63: C = 8'h00; 8'h64: C = 8'h8c; 8'h65: C = 8'hbc; 8'h66: C = 8'hd3; 8'h67: C = 8'h0a;
      8'h68: C = 8'hf7; 8'h69: C = 8'he4; 8'h6a: C = 8'h58; 8'h6b: C = 8'h05; 8'h6c: C = 8'hb8; 8'h6d: C = 8'hb3; 8'h6e: C = 8'h45; 8'h6f: C = 8'h06;
      8'h70: C = 8'hd0; 8'h71: C = 8'h2c; 8'h72: C = 8'h1e; 8'h73: C = 8'h8f; 8'h74: C = 8'hca; 8'h75: C = 8'h3f; 8'h76: C = 8'h0f; 8'h77: C = 8'h02;
      8'h78: C = 8'hc1; 8'h79: C = 8'haf; 8'h7a: C = 8'hbd; 8'h7b: C = 8'h03; 8'h7c: C = 8'h01; 8'h7d: C = 8'h13; 8'h7e: C = 8'h8a; 8'h7f: C = 8'h6b;
      8'h80: C = 8'h3a; 8'h81: C = 8'h91; 8'h82: C = 8'h11; 8'h83: C = 8'h41; 8'h84: C = 8'h4f; 8'h85: C = 8'h67; 8'h86: C = 8'hdc; 8'h87: C = 8'hea;
      8'h88: C = 8'h97; 8'h89: C = 8'hf2; 8'h8a: C = 8'hcf; 8'h8b: C = 8'hce; 8'h8c: C = 8'hf0; 8'h8d: C = 8'hb4; 8'h8e: C = 8'he6; 8'h8f: C = 8'h73;
      8'h90: C = 8'h96; 8'h91: C = 8'hac; 8'h92: C = 8'h74; 8'h93: C = 8'h22; 8'h94: C = 8'he7; 8'h95: C = 8'had; 8'h96: C = 8'h35; 8'h97: C = 8'h85;
      8'h98: C = 8'he2; 8'h99: C = 8'hf9; 8'h9a: C = 8'h37; 8'h9b: C = 8'he8; 8'h9c: C = 8'h1c; 8'h9d: C = 8'h75; 8'h9e: C = 8'hdf; 8'h9f: C = 8'h6e;
      8'ha0: C = 8'h47; 8'ha1: C = 8'hf1; 8'ha2: C = 8'h1a; 8'ha3: C = 8'h71; 8'ha4: C = 8'h1d; 8'ha5: C = 8'h29; 8'ha6: C = 8'hc5; 8'ha7: C = 8'h89;
      8'ha8: C = 8'h6f; 8'ha9: C = 8'hb7; 8'haa: C = 8'h62; 8'hab: C = 8'h0e; 8'hac: C = 8'haa; 8'had: C = 8'h18; 8'hae: C = 8'hbe; 8'haf: C = 8'h1b;
      8'hb0: C = 8'hfc; 8'hb1: C = 8'h56; 8'hb2: C = 8'h3e; 8'hb3: C = 8'h4b; 8'hb4: C = 8'hc6; 8'hb5: C = 8'hd2; 8'hb6: C = 8'h79; 8'hb7: C = 8'h20;
      8'hb8: C = 8'h9a; 8'hb9: C = 8'hdb; 8'hba: C = 8'hc0; 8'hbb: C = 8'hfe; 8'hbc: C = 8'h78; 8'hbd: C = 8'hcd; 8'hbe: C = 8'h5a; 8'hbf: C = 8'hf4;
      8'hc0: C = 8'h1f; 8'hc1: C = 8'hdd; 8'hc2: C = 8'ha8; 8'hc3: C = 8'h33; 8'hc4: C = 8'h88; 8'hc5: C = 8'h07; 8'hc6: C = 8'hc7; 8'hc7: C = 8'h31;
      8'hc8: C = 8'hb1; 8'hc9: C = 8'h12; 8'hca: C = 8'h10; 8'hcb: C = 8'h59; 8'hcc: C = 8'h27; 8'hcd: C = 8'h80; 8'hce: C = 8'hec; 8'hcf: C = 8'h5f;
      8'hd0: C = 8'h60; 8'hd1: C = 8'h51; 8'hd2: C = 8'h7f; 8'hd3: C = 8'ha9; 8'hd4: C = 8'h19; 8'hd5: C = 8'hb5; 8'hd6: C = 8'h4a; 8'hd7: C = 8'h0d;
      8'hd8: C = 8'h2d; 8'hd9: C = 8'he5; 8'hda: C = 8'h7a; 8'hdb: C = 8'h9f; 8'hdc: C = 8'h93; 8'hdd: C = 8'hc9; 8'hde: C = 8'h9c; 8'hdf: C = 8'hef;
      8'he0: C = 8'ha0; 8'he1: C = 8'he0; 8'he2: C = 8'h3b; 8'he3: C = 8'h4d; 8'he4: C = 8'hae; 8'he5: C = 8'h2a; 8'he6: C = 8'hf5; 8'he7: C = 8'hb0;
      8'he8: C = 8'hc8; 8'he9: C = 8'heb; 8'hea: C = 8'hbb; 8'heb: C = 8'h3c; 8'hec: C = 8'h83; 8'hed: C = 8'h53; 8'hee: C = 8'h99; 8'hef: C = 8'h61;
      8'hf0: C = 8'h17; 8'hf1: C = 8'h2b; 8'hf2: C = 8'h04; 8'hf3: C = 8'h7e; 8'hf4: C = 8'hba; 8'hf5: C = 8'h77; 8'hf6: C = 8'hd6; 8'hf7: C = 8'h26;
      8'hf8: C = 8'he1; 8'hf9: C = 8'h69; 8'hfa: C = 8'h14; 8'hfb: C = 8'h63; 8'hfc: C = 8'h55; 8'hfd: C = 8'h21; 8'hfe: C = 8'h0c; 8'hff: C = 8'h7d;
      default: C = 8'h00;
    endcase
  end

endmodule

// File: rtl/inv_sub_bytes_engine.sv
// rtl/inv_sub_bytes_engine.sv - multi-beat InvSubBytes engine with optional InvShiftRows on the result
// One state in, LANES bytes substituted per beat, result held in a register until taken.
module inv_sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES    = 4,
  parameter bit SHIFT_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  localparam int NBEATS = AES_NBYTES / LANES;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  logic [1:0]                  fsm;
  logic [CNT_W-1:0]            cnt;
  logic [3:0]                  base;
  logic [AES_BYTE_W-1:0]       st      [AES_NBYTES];
  logic [AES_BYTE_W-1:0]       st_sub  [AES_NBYTES];
  logic [AES_BYTE_W-1:0]       st_out  [AES_NBYTES];
  logic [AES_BYTE_W-1:0]       lane_in [LANES];
  logic [AES_BYTE_W-1:0]       lane_out[LANES];
  logic [AES_BLOCK_W-1:0]      out_next;
  logic [AES_BLOCK_W-1:0]      out_reg;

  assign base = 4'(cnt * LANES);

  always_comb begin
    for (int l = 0; l < LANES; l++) lane_in[l] = st[base + 4'(l)];
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inverse_substitution_box u_box (
      .clk (clk),
      .rst (rst),
      .A   (lane_in[g]),
      .C   (lane_out[g])
    );
  end

  always_comb begin
    st_sub = st;
    for (int l = 0; l < LANES; l++) st_sub[base + 4'(l)] = lane_out[l];
  end

  // InvShiftRows: row r rotates right by r, so out(r,c) takes the byte from column c-r.
  always_comb begin
    for (int i = 0; i < AES_NBYTES; i++) begin
      if (SHIFT_EN)
        st_out[i] = st_sub[st_idx(st_row(4'(i)), 2'(st_col(4'(i)) - st_row(4'(i))))];
      else
        st_out[i] = st_sub[4'(i)];
    end
  end

  always_comb begin
    out_next = '0;
    for (int i = 0; i < AES_NBYTES; i++) out_next[AES_BLOCK_W-1-8*i -: 8] = st_out[4'(i)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= ST_IDLE;
      cnt     <= '0;
      out_reg <= '0;
      for (int i = 0; i < AES_NBYTES; i++) st[4'(i)] <= 8'h00;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < AES_NBYTES; i++) st[4'(i)] <= in_data[AES_BLOCK_W-1-8*i -: 8];
            cnt <= '0;
            fsm <= ST_SUB;
          end
        end
        ST_SUB: begin
          st <= st_sub;
          if (cnt == LAST_BEAT) begin
            fsm     <= ST_DONE;
            out_reg <= out_next;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            fsm     <= ST_IDLE;
            out_reg <= '0;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm == ST_IDLE);
  assign out_valid = (fsm == ST_DONE);
  assign busy      = (fsm != ST_IDLE);
  assign out_data  = out_reg;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// tb/tb_inv_sub_bytes_engine.sv - scoreboard bench for inv_sub_bytes_engine across lane counts
module tb_inv_sub_bytes_engine;

  localparam logic [0:255][7:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         iv    [4];
  logic [127:0] idata [4];
  logic         ordy  [4];
  logic         ir    [5];
  logic         ov    [5];
  logic         bz    [5];
  logic [127:0] od    [5];

  logic [7:0]   inv_t [256];
  logic [127:0] exp_q [$];
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  // channel 0 feeds u0 (shifted) and u1 (unshifted); channels 1..3 drive the other lane widths
  inv_sub_bytes_engine #(.LANES(4), .SHIFT_EN(1'b1)) u0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(idata[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bz[0]));
  inv_sub_bytes_engine #(.LANES(4), .SHIFT_EN(1'b0)) u1 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[1]),
    .in_data(idata[0]), .out_valid(ov[1]), .out_ready(ordy[0]), .out_data(od[1]), .busy(bz[1]));
  inv_sub_bytes_engine #(.LANES(1), .SHIFT_EN(1'b1)) u2 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[2]),
    .in_data(idata[1]), .out_valid(ov[2]), .out_ready(ordy[1]), .out_data(od[2]), .busy(bz[2]));
  inv_sub_bytes_engine #(.LANES(2), .SHIFT_EN(1'b1)) u3 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[3]),
    .in_data(idata[2]), .out_valid(ov[3]), .out_ready(ordy[2]), .out_data(od[3]), .busy(bz[3]));
  inv_sub_bytes_engine #(.LANES(16), .SHIFT_EN(1'b1)) u4 (.clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[4]),
    .in_data(idata[3]), .out_valid(ov[4]), .out_ready(ordy[3]), .out_data(od[4]), .busy(bz[4]));

  function automatic logic [127:0] model(input logic [127:0] d, input bit sh);
    logic [7:0]   b [16];
    logic [127:0] r;
    int           src;
    r = '0;
    for (int i = 0; i < 16; i++) b[i] = inv_t[d[127-8*i -: 8]];
    for (int i = 0; i < 16; i++) begin
      src = sh ? ((i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)) : i;
      r[127-8*i -: 8] = b[src];
    end
    return r;
  endfunction

  task automatic run0(input logic [127:0] d, output int lat, output logic [127:0] g0, output logic [127:0] g1);
    @(negedge clk);
    iv[0] = 1'b1; idata[0] = d; ordy[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    lat = 1;
    while (!ov[0] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    g0 = od[0]; g1 = od[1];
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests += 4;
    if (ir[0] !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", ir[0]); end
    if (ov[0] !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", ov[0]); end
    if (bz[0] !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bz[0]); end
    if (od[0] !== 128'h0) begin fails++; $display("FAIL reset_out_data: got %h want 0", od[0]); end
  endtask

  task automatic test_sub_vectors();
    logic [127:0] vin  [3];
    logic [127:0] vexp [3];
    logic [127:0] g0, g1, e;
    int lat;
    vin[0] = {16{8'h63}}; vexp[0] = {16{8'h00}};
    vin[1] = {16{8'h00}}; vexp[1] = {16{8'h52}};
    vin[2] = {16{8'h52}}; vexp[2] = {16{8'h48}};
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(vexp[k]);
      run0(vin[k], lat, g0, g1);
      e = exp_q.pop_front();
      tests += 3;
      if (lat !== 5) begin fails++; $display("FAIL sub_latency[%0d]: got %0d want 5", k, lat); end
      if (g0 !== e) begin fails++; $display("FAIL sub_data_shift[%0d]: got %h want %h", k, g0, e); end
      if (g1 !== e) begin fails++; $display("FAIL sub_data_noshift[%0d]: got %h want %h", k, g1, e); end
    end
    @(negedge clk);
    tests += 2;
    if (ov[0] !== 1'b0) begin fails++; $display("FAIL post_hs_valid: got %b want 0", ov[0]); end
    if (od[0] !== 128'h0) begin fails++; $display("FAIL post_hs_data: got %h want 0", od[0]); end
  endtask

  task automatic test_shift_rows();
    logic [127:0] g0, g1, e0, e1;
    int lat;
    exp_q.push_back(128'h000d0a07_04010e0b_0805020f_0c090603);
    exp_q.push_back(128'h00010203_04050607_08090a0b_0c0d0e0f);
    run0(128'h637c777bf26b6fc53001672bfed7ab76, lat, g0, g1);
    e0 = exp_q.pop_front();
    e1 = exp_q.pop_front();
    tests += 2;
    if (g0 !== e0) begin fails++; $display("FAIL shift_en1: got %h want %h", g0, e0); end
    if (g1 !== e1) begin fails++; $display("FAIL shift_en0: got %h want %h", g1, e1); end
  endtask

  task automatic test_backpressure();
    logic [127:0] e;
    int n;
    exp_q.push_back({16{8'h52}});
    @(negedge clk);
    iv[0] = 1'b1; idata[0] = {16{8'h00}}; ordy[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 100) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    for (int c = 0; c < 10; c++) begin
      iv[0] = 1'b1; idata[0] = {16{8'h52}};
      @(posedge clk);
      @(negedge clk);
      tests += 3;
      if (ov[0] !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b want 1", c, ov[0]); end
      if (od[0] !== e) begin fails++; $display("FAIL bp_data[%0d]: got %h want %h", c, od[0], e); end
      if (ir[0] !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, ir[0]); end
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[0] = 1'b0;
    tests += 2;
    if (ir[0] !== 1'b1) begin fails++; $display("FAIL bubble_in_ready: got %b want 1", ir[0]); end
    if (ov[0] !== 1'b0) begin fails++; $display("FAIL bubble_valid: got %b want 0", ov[0]); end
    exp_q.push_back({16{8'h48}});
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    tests += 1;
    if (bz[0] !== 1'b1 || ir[0] !== 1'b0) begin
      fails++; $display("FAIL second_accept: busy %b in_ready %b want 1 0", bz[0], ir[0]);
    end
    n = 0;
    while (!ov[0] && n < 100) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    tests += 1;
    if (od[0] !== e) begin fails++; $display("FAIL second_data: got %h want %h", od[0], e); end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [127:0] g0, g1, e;
    int lat;
    @(negedge clk);
    iv[0] = 1'b1; idata[0] = {16{8'h63}};
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests += 4;
    if (ir[0] !== 1'b1) begin fails++; $display("FAIL rst_mid_in_ready: got %b want 1", ir[0]); end
    if (ov[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", ov[0]); end
    if (bz[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", bz[0]); end
    if (od[0] !== 128'h0) begin fails++; $display("FAIL rst_mid_data: got %h want 0", od[0]); end
    repeat (6) @(negedge clk);
    tests += 1;
    if (ov[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_no_output: got %b want 0", ov[0]); end
    exp_q.push_back({16{8'h52}});
    run0({16{8'h00}}, lat, g0, g1);
    e = exp_q.pop_front();
    tests += 2;
    if (g0 !== e) begin fails++; $display("FAIL rst_mid_next: got %h want %h", g0, e); end
    if (lat !== 5) begin fails++; $display("FAIL rst_mid_latency: got %0d want 5", lat); end
  endtask

  task automatic test_exhaustive();
    logic [127:0] d, e, g0, g1;
    int lat;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) begin
        d[127-8*j -: 8] = FWD[16*k + j];
        e[127-8*j -: 8] = 8'(16*k + j);
      end
      exp_q.push_back(e);
      run0(d, lat, g0, g1);
      e = exp_q.pop_front();
      tests += 1;
      if (g1 !== e) begin fails++; $display("FAIL roundtrip[%0d]: got %h want %h", k, g1, e); end
    end
  endtask

  task automatic sweep_one(input int ch, input int inst, input int n);
    logic [127:0] q [$];
    logic [127:0] e;
    int sent, got, cyc;
    bit timeout;
    sent = 0; got = 0; cyc = 0; timeout = 1'b0;
    fork
      begin
        while (sent < n && !timeout) begin
          @(negedge clk);
          iv[ch] = ($urandom_range(0, 3) != 0);
          idata[ch] = {$urandom, $urandom, $urandom, $urandom};
          if (iv[ch] && ir[inst]) begin
            q.push_back(model(idata[ch], 1'b1));
            sent++;
          end
        end
        @(negedge clk);
        iv[ch] = 1'b0;
      end
      begin
        while (got < n && !timeout) begin
          @(negedge clk);
          cyc++;
          if (cyc > 40 * n + 1000) timeout = 1'b1;
          ordy[ch] = ($urandom_range(0, 2) != 0);
          if (!ov[inst]) begin
            tests++;
            if (od[inst] !== 128'h0) begin fails++; $display("FAIL sweep%0d_idle_data: got %h want 0", inst, od[inst]); end
          end else if (ordy[ch]) begin
            tests++;
            if (q.size() == 0) begin
              fails++; $display("FAIL sweep%0d_extra_output: got %h want none", inst, od[inst]);
            end else begin
              e = q.pop_front();
              if (od[inst] !== e) begin fails++; $display("FAIL sweep%0d_data: got %h want %h", inst, od[inst], e); end
            end
            got++;
          end
        end
        ordy[ch] = 1'b0;
      end
    join
    tests++;
    if (timeout) begin fails++; $display("FAIL sweep%0d_timeout: got %0d outputs want %0d", inst, got, n); end
  endtask

  task automatic test_sweep();
    sweep_one(0, 0, 250);
    sweep_one(1, 2, 250);
    sweep_one(2, 3, 250);
    sweep_one(3, 4, 250);
  endtask

  initial begin
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      iv[c] = 1'b0; idata[c] = '0; ordy[c] = 1'b0;
    end
    for (int x = 0; x < 256; x++) inv_t[FWD[x]] = 8'(x);
    test_reset();
    test_sub_vectors();
    test_shift_rows();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
